result_capture: RTL

RESULT_CAPTURE -- requirements
Module: result_capture

---
 rtl/result_capture.sv | 129 ++++++++++++
 1 files changed

// File: rtl/result_capture.sv
// Captures DEPTH FPU results into slots, compares each against an expected value and keeps pass/fail counts.
// Define RESULT_CAPTURE_NAN_EQ_EN to treat any NaN result as matching any NaN expected value.
module result_capture #(
  parameter int DEPTH = 10,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  output logic         res_ready,
  output logic [3:0]   wr_idx,
  input  logic [W-1:0] exp_data,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [W-1:0] rd_data,
  output logic         rd_match,
  output logic [3:0]   pass_cnt,
  output logic [3:0]   fail_cnt,
  output logic         done
);

  // state   | meaning
  // CAPTURE | accepting results, res_ready high
  // DONE    | all DEPTH slots filled, results ignored until clear/rst
  typedef enum logic {
    CAPTURE = 1'b0,
    DONE    = 1'b1
  } state_e;

  localparam logic [3:0] LAST_IDX  = 4'(DEPTH - 1);
  localparam logic [4:0] DEPTH_EXT = 5'(DEPTH);

  state_e       state_q, state_d;
  logic [3:0]   wr_idx_q, wr_idx_d;
  logic [3:0]   pass_q, pass_d;
  logic [3:0]   fail_q, fail_d;
  logic [W-1:0] slot_q [DEPTH];
  logic [DEPTH-1:0] flag_q;
  logic [W-1:0] rd_data_q;
  logic         rd_match_q;
  logic         capture;
  logic         match;
  logic         rd_in_range;

`ifdef RESULT_CAPTURE_NAN_EQ_EN
  logic res_nan, exp_nan;
  assign res_nan = (res_data[30:23] == 8'hFF) && (res_data[22:0] != '0);
  assign exp_nan = (exp_data[30:23] == 8'hFF) && (exp_data[22:0] != '0);
  assign match   = (res_data == exp_data) || (res_nan && exp_nan);
`else
  assign match = (res_data == exp_data);
`endif

  assign res_ready   = (state_q == CAPTURE);
  assign capture     = res_valid && res_ready && !clear;
  assign rd_in_range = ({1'b0, rd_idx} < DEPTH_EXT);

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    if (clear) begin
      state_d  = CAPTURE;
      wr_idx_d = '0;
      pass_d   = '0;
      fail_d   = '0;
    end else if (capture) begin
      if (match) pass_d = pass_q + 4'd1;
      else       fail_d = fail_q + 4'd1;
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d = '0;
        state_d  = DONE;
      end else begin
        wr_idx_d = wr_idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CAPTURE;
      wr_idx_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  // Slot storage survives clear; only rst wipes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      flag_q <= '0;
    end else if (capture) begin
      slot_q[wr_idx_q] <= res_data;
      flag_q[wr_idx_q] <= match;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_match_q <= 1'b0;
    end else if (rd_en) begin
      if (rd_in_range) begin
        rd_data_q  <= slot_q[rd_idx];
        rd_match_q <= flag_q[rd_idx];
      end else begin
        rd_data_q  <= '0;
        rd_match_q <= 1'b0;
      end
    end
  end

  assign wr_idx   = wr_idx_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign done     = (state_q == DONE);
  assign rd_data  = rd_data_q;
  assign rd_match = rd_match_q;

endmodule
